// File: rtl/bnn_xnor_neuron.sv
// Binary XNOR-popcount neuron: accumulates popcount(~(act ^ wgt)) over
// N_CHUNKS accepted chunks, then presents the sum and a thresholded bit
// through a valid/ready handshake.
module bnn_xnor_neuron #(
    parameter int unsigned CHUNK_W  = 8,
    parameter int unsigned N_CHUNKS = 4,
    localparam int unsigned CNT_W   = $clog2(CHUNK_W * N_CHUNKS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [CNT_W-1:0]   thresh,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CHUNK_W-1:0] act_in,
    input  logic [CHUNK_W-1:0] wgt_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_bit,
    output logic [CNT_W-1:0]   out_sum,
    output logic               busy
);

    localparam int unsigned CCW = $clog2(N_CHUNKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CCW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] pc;
    logic             accept;

    // Count of agreeing bit positions (+1*+1 or -1*-1) in one chunk.
    function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
        logic [CNT_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < CHUNK_W; i++) begin
            s = s + CNT_W'(v[i]);
        end
        return s;
    endfunction

    assign pc       = popcount(~(act_in ^ wgt_in));
    assign in_ready = !rst && (state_q != DONE);
    assign accept   = in_valid && in_ready;

    // Result is only visible while in DONE; otherwise outputs read zero.
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_valid ? acc_q : '0;
    assign out_bit   = out_valid && (acc_q >= thr_q);
    assign busy      = (state_q != IDLE);

    // State, accumulator, threshold and chunk counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            thr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            thr_q   <= thr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; clear overrides every handshake in every state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        thr_d   = thr_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d   = pc;
                        thr_d   = thresh;
                        cnt_d   = CCW'(1);
                        state_d = (N_CHUNKS == 1) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d = acc_q + pc;
                        cnt_d = cnt_q + CCW'(1);
                        if (cnt_q == CCW'(N_CHUNKS - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule
